// File: rtl/bsg_link_pearl_pkg.sv
// Shared types for the SDR link pearl bring-up sequencer: state encoding,
// per-channel control bundle and the state-to-control decode.
package bsg_link_pearl_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_IO_RESET   = 3'd1,
        ST_CORE_RESET = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_DRAIN      = 3'd4
    } bsg_link_pearl_seq_state_e;

    typedef struct packed {
        logic link_i_disable;
        logic link_o_disable;
        logic io_reset;
        logic core_reset;
        logic ready;
    } bsg_link_pearl_seq_ctrl_s;

    localparam int retrain_cnt_w_lp = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Pure Moore decode: control outputs depend on the state register alone.
    function automatic bsg_link_pearl_seq_ctrl_s decode_ctrl(input bsg_link_pearl_seq_state_e st);
        bsg_link_pearl_seq_ctrl_s c;
        case (st)
            ST_OFF:        c = '{link_i_disable: 1'b1, link_o_disable: 1'b1, io_reset: 1'b1, core_reset: 1'b1, ready: 1'b0};
            ST_IO_RESET:   c = '{link_i_disable: 1'b0, link_o_disable: 1'b0, io_reset: 1'b1, core_reset: 1'b1, ready: 1'b0};
            ST_CORE_RESET: c = '{link_i_disable: 1'b0, link_o_disable: 1'b0, io_reset: 1'b0, core_reset: 1'b1, ready: 1'b0};
            ST_ACTIVE:     c = '{link_i_disable: 1'b0, link_o_disable: 1'b0, io_reset: 1'b0, core_reset: 1'b0, ready: 1'b1};
            ST_DRAIN:      c = '{link_i_disable: 1'b0, link_o_disable: 1'b1, io_reset: 1'b0, core_reset: 1'b0, ready: 1'b0};
            default:       c = '{link_i_disable: 1'b1, link_o_disable: 1'b1, io_reset: 1'b1, core_reset: 1'b1, ready: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bsg_link_sdr_pearl_seq_chan.sv
// One channel of the pearl bring-up sequencer: Moore FSM plus dwell down-counter.
// Optional retrain counter enabled by BSG_LINK_PEARL_SEQ_RETRAIN_CNT_EN.
module bsg_link_sdr_pearl_seq_chan
    import bsg_link_pearl_pkg::*;
#(
    parameter int io_hold_p   = 16,
    parameter int core_hold_p = 16,
    parameter int drain_p     = 32
)
(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    output bsg_link_pearl_seq_ctrl_s ctrl_o
`ifdef BSG_LINK_PEARL_SEQ_RETRAIN_CNT_EN
    ,
    output logic [retrain_cnt_w_lp-1:0] retrain_cnt_o
`endif
);

    localparam int cnt_w_lp = $clog2(max3(io_hold_p, core_hold_p, drain_p) + 1);
    typedef logic [cnt_w_lp-1:0] cnt_t;

    localparam cnt_t io_load_lp    = cnt_t'(io_hold_p - 1);
    localparam cnt_t core_load_lp  = cnt_t'(core_hold_p - 1);
    localparam cnt_t drain_load_lp = cnt_t'(drain_p - 1);

    bsg_link_pearl_seq_state_e state_q, state_d;
    cnt_t                      cnt_q, cnt_d;

    // Next-state and dwell-counter logic; the counter only decrements while non-zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (en_i) begin
                    state_d = ST_IO_RESET;
                    cnt_d   = io_load_lp;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_IO_RESET: begin
                if (!en_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CORE_RESET;
                    cnt_d   = core_load_lp;
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end
            ST_CORE_RESET: begin
                if (!en_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end
            ST_ACTIVE: begin
                if (!en_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = drain_load_lp;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl_o = decode_ctrl(state_q);

`ifdef BSG_LINK_PEARL_SEQ_RETRAIN_CNT_EN
    logic [retrain_cnt_w_lp-1:0] retrain_q, retrain_d;
    logic                        retrain_evt_s;

    assign retrain_evt_s = (state_q == ST_ACTIVE) && (state_d == ST_DRAIN);

    // Saturating count of ACTIVE->DRAIN transitions.
    always_comb begin
        retrain_d = retrain_q;
        if (retrain_evt_s && (retrain_q != 4'd15)) begin
            retrain_d = retrain_q + 4'd1;
        end else begin
            retrain_d = retrain_q;
        end
    end

    // Retrain counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            retrain_q <= 4'd0;
        end else begin
            retrain_q <= retrain_d;
        end
    end

    assign retrain_cnt_o = retrain_q;
`endif

endmodule

// File: rtl/bsg_link_sdr_pearl_seq.sv
// Multi-channel SDR link pearl bring-up sequencer (independent channel FSMs).
// Optional per-channel retrain counters under BSG_LINK_PEARL_SEQ_RETRAIN_CNT_EN.
module bsg_link_sdr_pearl_seq
    import bsg_link_pearl_pkg::*;
#(
    parameter int num_channels_p = 2,
    parameter int io_hold_p      = 16,
    parameter int core_hold_p    = 16,
    parameter int drain_p        = 32
)
(
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [num_channels_p-1:0] en_i,
    output logic [num_channels_p-1:0] link_i_disable_o,
    output logic [num_channels_p-1:0] link_o_disable_o,
    output logic [num_channels_p-1:0] io_reset_o,
    output logic [num_channels_p-1:0] core_reset_o,
    output logic [num_channels_p-1:0] ready_o,
    output logic                      all_ready_o
`ifdef BSG_LINK_PEARL_SEQ_RETRAIN_CNT_EN
    ,
    output logic [num_channels_p*retrain_cnt_w_lp-1:0] retrain_cnt_o
`endif
);

    bsg_link_pearl_seq_ctrl_s chan_ctrl_s [num_channels_p];

    for (genvar ch = 0; ch < num_channels_p; ch++) begin : g_chan
        bsg_link_sdr_pearl_seq_chan #(
            .io_hold_p   (io_hold_p),
            .core_hold_p (core_hold_p),
            .drain_p     (drain_p)
        ) u_chan (
            .clk_i         (clk_i),
            .reset_n_i     (reset_n_i),
            .en_i          (en_i[ch]),
            .ctrl_o        (chan_ctrl_s[ch])
`ifdef BSG_LINK_PEARL_SEQ_RETRAIN_CNT_EN
            ,
            .retrain_cnt_o (retrain_cnt_o[ch*retrain_cnt_w_lp +: retrain_cnt_w_lp])
`endif
        );

        assign link_i_disable_o[ch] = chan_ctrl_s[ch].link_i_disable;
        assign link_o_disable_o[ch] = chan_ctrl_s[ch].link_o_disable;
        assign io_reset_o[ch]       = chan_ctrl_s[ch].io_reset;
        assign core_reset_o[ch]     = chan_ctrl_s[ch].core_reset;
        assign ready_o[ch]          = chan_ctrl_s[ch].ready;
    end

    // ready_o is itself a decode of state registers, so the AND adds no latency.
    assign all_ready_o = &ready_o;

endmodule
